// File: rtl/mantle_concat_stream.sv
`default_nettype none
// ============================================================================
// Module      : mantle_concat_stream
// Description : Merges two ready/valid word streams into packets of N1 words
//               from in1 followed by N2 words from in2. Each output word is
//               tagged with its packet index, and the final word is flagged.
//               A counter tracks completed packets.
// Revision    : 1.0 - initial release
// ============================================================================
module mantle_concat_stream #(
    parameter int WIDTH = 32,
    parameter int N1    = 9,
    parameter int N2    = 6,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in2_valid,
    output logic             in2_ready,
    input  logic [WIDTH-1:0] in2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [10:0]      out_idx,
    output logic [CNT_W-1:0] pkt_count
);

    // The word counter must span the larger segment; a 1-word segment still
    // needs one bit so the counter is never zero-width.
    localparam int C_MAXN   = (N1 > N2) ? N1 : N2;
    localparam int C_WCNT_W = (C_MAXN > 1) ? $clog2(C_MAXN) : 1;

    localparam logic [C_WCNT_W-1:0] C_N1_LAST = C_WCNT_W'(N1 - 1);
    localparam logic [C_WCNT_W-1:0] C_N2_LAST = C_WCNT_W'(N2 - 1);
    localparam logic [10:0]         C_N1_IDX  = 11'(N1);

    typedef enum logic [0:0] {
        SEL1 = 1'b0,
        SEL2 = 1'b1
    } state_t;

    state_t              r_state;
    logic [C_WCNT_W-1:0] r_wcnt;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_last;
    logic [10:0]         r_out_idx;
    logic [CNT_W-1:0]    r_pkt_count;

    logic             w_pipe_ready;
    logic             w_acc1;
    logic             w_acc2;
    logic             w_accept;
    logic             w_seg_end;
    logic [WIDTH-1:0] w_sel_data;
    logic [10:0]      w_next_idx;

    // The output register can take a new word when empty or being drained.
    // Readies are held low during reset so no handshake straddles it.
    assign w_pipe_ready = !r_out_valid || out_ready;
    assign in1_ready    = (r_state == SEL1) && w_pipe_ready && !RESET;
    assign in2_ready    = (r_state == SEL2) && w_pipe_ready && !RESET;

    assign w_acc1     = in1_valid && in1_ready;
    assign w_acc2     = in2_valid && in2_ready;
    assign w_accept   = w_acc1 || w_acc2;
    assign w_seg_end  = (r_state == SEL1) ? (r_wcnt == C_N1_LAST) : (r_wcnt == C_N2_LAST);
    assign w_sel_data = (r_state == SEL1) ? in1_data : in2_data;
    assign w_next_idx = (r_state == SEL1) ? 11'(r_wcnt) : (C_N1_IDX + 11'(r_wcnt));

    // Segment sequencer: advance the word count on each accepted word and
    // switch sources after the last word of the current segment.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= SEL1;
            r_wcnt  <= '0;
        end else if (w_accept) begin
            if (w_seg_end) begin
                r_state <= (r_state == SEL1) ? SEL2 : SEL1;
                r_wcnt  <= '0;
            end else begin
                r_wcnt  <= r_wcnt + C_WCNT_W'(1);
            end
        end
    end

    // Output register: load on accept, hold under backpressure, and drop
    // valid once the word has been taken with nothing new behind it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_idx   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= (r_state == SEL2) && (r_wcnt == C_N2_LAST);
            r_out_idx   <= w_next_idx;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Completed-packet counter, bumped when the flagged final word leaves.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pkt_count <= '0;
        end else if (r_out_valid && out_ready && r_out_last) begin
            r_pkt_count <= r_pkt_count + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_idx   = r_out_idx;
    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_mantle_concat_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_mantle_concat_stream
// Description : Scoreboard bench for mantle_concat_stream. The main instance
//               uses N1=9/N2=6; a second instance uses N1=1/N2=1/CNT_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mantle_concat_stream;

    typedef struct {
        logic [31:0] d;
        logic [10:0] idx;
        logic        last;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in1_valid = 1'b0, in2_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in1_data = '0, in2_data = '0;
    logic        in1_ready, in2_ready, out_valid, out_last;
    logic [31:0] out_data;
    logic [10:0] out_idx;
    logic [15:0] pkt_count;

    logic        d2_in1_valid = 1'b0, d2_in2_valid = 1'b0, d2_out_ready = 1'b1;
    logic [31:0] d2_in1_data = '0, d2_in2_data = '0;
    logic        d2_in1_ready, d2_in2_ready, d2_out_valid, d2_out_last;
    logic [31:0] d2_out_data;
    logic [10:0] d2_out_idx;
    logic [1:0]  d2_pkt_count;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];
    exp_t        sb[$];
    exp_t        sb2[$];
    logic        en1 = 1'b0, en2 = 1'b0;
    logic        take1 = 1'b0, take2 = 1'b0;
    int          n_take = 0;
    int          stall_left = 0;
    logic        stall_arm = 1'b0;
    logic        mon_en = 1'b1;
    logic [15:0] exp_pkts = '0;
    int          lasts_seen = 0;
    logic [1:0]  exp_pk2 = '0;

    always #5 CLK = ~CLK;

    mantle_concat_stream #(.WIDTH(32), .N1(9), .N2(6), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .in2_valid(in2_valid), .in2_ready(in2_ready), .in2_data(in2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_idx(out_idx), .pkt_count(pkt_count)
    );

    mantle_concat_stream #(.WIDTH(32), .N1(1), .N2(1), .CNT_W(2)) dut2 (
        .CLK(CLK), .RESET(RESET),
        .in1_valid(d2_in1_valid), .in1_ready(d2_in1_ready), .in1_data(d2_in1_data),
        .in2_valid(d2_in2_valid), .in2_ready(d2_in2_ready), .in2_data(d2_in2_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
        .out_last(d2_out_last), .out_idx(d2_out_idx), .pkt_count(d2_pkt_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One packet: 9 in1 words then 6 in2 words, expected idx 0..14.
    task automatic push_packet(input logic [31:0] b1, input logic [31:0] b2);
        for (int k = 0; k < 9; k++) begin
            q1.push_back(b1 + 32'(k));
            sb.push_back('{d: b1 + 32'(k), idx: 11'(k), last: 1'b0});
        end
        for (int k = 0; k < 6; k++) begin
            q2.push_back(b2 + 32'(k));
            sb.push_back('{d: b2 + 32'(k), idx: 11'(9 + k), last: (k == 5)});
        end
    endtask

    // One clock of stimulus, driven at the falling edge; handshakes that will
    // occur at the next rising edge are recorded in take1/take2.
    task automatic step(input logic rst_v);
        @(negedge CLK);
        if (take1) void'(q1.pop_front());
        if (take2) void'(q2.pop_front());
        RESET = rst_v;
        if (stall_arm && out_valid && out_data == 32'h104) begin
            stall_left = 3;
            stall_arm  = 1'b0;
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
        in1_valid = en1 && (q1.size() > 0);
        in1_data  = in1_valid ? q1[0] : 32'h0;
        in2_valid = en2 && (q2.size() > 0);
        in2_data  = in2_valid ? q2[0] : 32'h0;
        #1;
        take1 = in1_valid && in1_ready;
        take2 = in2_valid && in2_ready;
        if (take1) n_take++;
        if (take2) n_take++;
    endtask

    // Monitor for the main instance: pop expected word on each output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (mon_en && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 64'(out_data), 64'hdead);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_idx", 64'(out_idx), 64'(e.idx));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    chk("pkt_count_at_hs", 64'(pkt_count), 64'(exp_pkts));
                    if (e.last) begin
                        exp_pkts = exp_pkts + 16'd1;
                        lasts_seen++;
                    end
                end
            end
        end
    end

    // Monitor for the degenerate 1+1 instance with its 2-bit wrapping counter.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (d2_out_valid && d2_out_ready) begin
                if (sb2.size() == 0) begin
                    chk("d2_unexpected_word", 64'(d2_out_data), 64'hdead);
                end else begin
                    e = sb2.pop_front();
                    chk("d2_out_data", 64'(d2_out_data), 64'(e.d));
                    chk("d2_out_idx", 64'(d2_out_idx), 64'(e.idx));
                    chk("d2_out_last", 64'(d2_out_last), 64'(e.last));
                    chk("d2_pkt_count", 64'(d2_pkt_count), 64'(exp_pk2));
                    if (e.last) exp_pk2 = exp_pk2 + 2'd1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1_acc;
        int stalls;
        int lasts0;
        int i1;
        int i2;

        // ---------------- reset state ----------------
        step(1'b1);
        chk("rst_in1_ready", 64'(in1_ready), 64'd0);
        chk("rst_in2_ready", 64'(in2_ready), 64'd0);
        step(1'b1);
        step(1'b0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_sel1_in1_ready", 64'(in1_ready), 64'd1);
        chk("rst_sel1_in2_ready", 64'(in2_ready), 64'd0);

        // ---------------- full throughput ----------------
        push_packet(32'h100, 32'h200);
        en1 = 1'b1;
        en2 = 1'b1;
        step(1'b0);
        for (int i = 0; i < 15; i++) begin
            step(1'b0);
            chk("t1_no_bubble", 64'(out_valid), 64'd1);
        end
        step(1'b0);
        chk("t1_valid_clear", 64'(out_valid), 64'd0);
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);

        // ---------------- backpressure ----------------
        push_packet(32'h100, 32'h200);
        stall_arm = 1'b1;
        stalls = 0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0);
            if (!out_ready) begin
                stalls++;
                chk("t2_hold_data", 64'(out_data), 64'h104);
                chk("t2_hold_idx", 64'(out_idx), 64'd4);
                chk("t2_in1_ready_stall", 64'(in1_ready), 64'd0);
            end
        end
        chk("t2_stall_cycles", 64'(stalls), 64'd3);
        chk("t2_pkt_count", 64'(pkt_count), 64'd2);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- source ordering ----------------
        push_packet(32'h300, 32'h400);
        en1 = 1'b0;
        en2 = 1'b1;
        n1_acc = 0;
        for (int i = 0; i < 30; i++) begin
            en1 = (i >= 5);
            step(1'b0);
            if (n1_acc < 9) chk("t3_in2_ready_low", 64'(in2_ready), 64'd0);
            if (take1) n1_acc++;
        end
        chk("t3_pkt_count", 64'(pkt_count), 64'd3);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- back-to-back packets ----------------
        lasts0 = lasts_seen;
        push_packet(32'h600, 32'h700);
        push_packet(32'h800, 32'h900);
        push_packet(32'ha00, 32'hb00);
        step(1'b0);
        for (int i = 0; i < 45; i++) begin
            step(1'b0);
            chk("t4_no_bubble", 64'(out_valid), 64'd1);
        end
        step(1'b0);
        chk("t4_pkt_count", 64'(pkt_count), 64'd6);
        chk("t4_lasts", 64'(lasts_seen - lasts0), 64'd3);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- reset mid-packet ----------------
        mon_en = 1'b0;
        push_packet(32'hc00, 32'hd00);
        sb.delete();
        n_take = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0);
            if (n_take >= 11) break;
        end
        chk("t5_took_11", 64'(n_take), 64'd11);
        en1 = 1'b0;
        en2 = 1'b0;
        step(1'b1);
        chk("t5_rst_in1_ready", 64'(in1_ready), 64'd0);
        chk("t5_rst_in2_ready", 64'(in2_ready), 64'd0);
        q1.delete();
        q2.delete();
        step(1'b0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_pkt_count", 64'(pkt_count), 64'd0);
        chk("t5_in1_ready", 64'(in1_ready), 64'd1);
        chk("t5_in2_ready", 64'(in2_ready), 64'd0);
        exp_pkts = '0;
        mon_en = 1'b1;
        push_packet(32'h500, 32'h600);
        en1 = 1'b1;
        en2 = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0);
        chk("t5_pkt_after", 64'(pkt_count), 64'd1);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- degenerate sizes and counter wrap ----------------
        for (int k = 0; k < 5; k++) begin
            sb2.push_back('{d: 32'ha0 + 32'(k), idx: 11'd0, last: 1'b0});
            sb2.push_back('{d: 32'hb0 + 32'(k), idx: 11'd1, last: 1'b1});
        end
        i1 = 0;
        i2 = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            d2_out_ready = 1'b1;
            d2_in1_valid = (i1 < 5);
            d2_in1_data  = 32'ha0 + 32'(i1);
            d2_in2_valid = (i2 < 5);
            d2_in2_data  = 32'hb0 + 32'(i2);
            #1;
            if (d2_in1_valid && d2_in1_ready) i1++;
            if (d2_in2_valid && d2_in2_ready) i2++;
        end
        chk("t6_pkt_count_wrap", 64'(d2_pkt_count), 64'd1);
        chk("t6_sb_empty", 64'(sb2.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
